// File: rtl/face_anim_source.sv
// -----------------------------------------------------------------------------
// face_anim_source
//
// Pixel source for the LCD animation path. It answers every (x, y) address
// scanned by the downstream SPI LCD driver with a registered RGB565 colour,
// drawing a face made of two eyes and a mouth. A frame-synchronous state
// machine switches between IDLE, BLINK and SMILE. The state only changes at
// a frame start, so every frame is drawn with a single state.
//
// Ports:
//   clk         in   1   system clock (only clock)
//   rst         in   1   synchronous reset, active-high
//   go          in   1   smile request, a one-cycle pulse is enough
//   ram_addr_x  in   8   pixel column being scanned
//   ram_addr_y  in   8   pixel row being scanned
//   ram_data    out 16   RGB565 colour of the address presented one cycle earlier
//   anim_state  out  2   0 = IDLE, 1 = BLINK, 2 = SMILE
//   frame_tick  out  1   one-cycle pulse when a frame start is registered
// -----------------------------------------------------------------------------
module face_anim_source #(
    parameter int LCD_W        = 132,
    parameter int LCD_H        = 162,
    parameter int IDLE_FRAMES  = 90,
    parameter int BLINK_FRAMES = 4,
    parameter int SMILE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [7:0]  ram_addr_x,
    input  logic [7:0]  ram_addr_y,
    output logic [15:0] ram_data,
    output logic [1:0]  anim_state,
    output logic        frame_tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLINK = 2'd1;
    localparam logic [1:0] ST_SMILE = 2'd2;

    localparam logic [15:0] COL_BG    = 16'h2935;
    localparam logic [15:0] COL_EYE   = 16'hFFFF;
    localparam logic [15:0] COL_MOUTH = 16'hF800;

    localparam logic [8:0] LCD_W_L = 9'(LCD_W);
    localparam logic [8:0] LCD_H_L = 9'(LCD_H);

    // fcnt value seen at the frame start that ends each timed state
    localparam logic [7:0] IDLE_LAST  = 8'(IDLE_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] SMILE_LAST = 8'(SMILE_FRAMES - 1);

    // Inclusive range test on an 8-bit coordinate.
    function automatic logic in_span(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Colour of one on-screen or off-screen pixel for a given face state.
    function automatic logic [15:0] pixel_colour(input logic [7:0] x,
                                                 input logic [7:0] y,
                                                 input logic [1:0] st);
        logic        on_screen;
        logic        eye_col;
        logic        eye_row;
        logic        mouth;
        logic [15:0] colour;
        on_screen = ({1'b0, x} < LCD_W_L) && ({1'b0, y} < LCD_H_L);
        eye_col   = in_span(x, 8'd36, 8'd51) || in_span(x, 8'd80, 8'd95);
        if (st == ST_BLINK) begin
            eye_row = in_span(y, 8'd57, 8'd58);
        end else begin
            eye_row = in_span(y, 8'd50, 8'd65);
        end
        if (st == ST_SMILE) begin
            // Wider lip plus raised mouth corners on both sides
            mouth = (in_span(y, 8'd110, 8'd113) && in_span(x, 8'd52, 8'd79)) ||
                    (in_span(y, 8'd106, 8'd109) &&
                     (in_span(x, 8'd46, 8'd51) || in_span(x, 8'd80, 8'd85)));
        end else begin
            mouth = in_span(y, 8'd112, 8'd113) && in_span(x, 8'd52, 8'd79);
        end
        if (!on_screen) begin
            colour = COL_BG;
        end else if (eye_col && eye_row) begin
            colour = COL_EYE;
        end else if (mouth) begin
            colour = COL_MOUTH;
        end else begin
            colour = COL_BG;
        end
        return colour;
    endfunction

    logic [7:0]  prev_x_q,     prev_x_d;
    logic [7:0]  prev_y_q,     prev_y_d;
    logic [1:0]  state_q,      state_d;
    logic [7:0]  fcnt_q,       fcnt_d;
    logic        go_pending_q, go_pending_d;
    logic        first_q,      first_d;
    logic [15:0] ram_data_q,   ram_data_d;
    logic        frame_tick_q, frame_tick_d;

    logic at_origin;
    logic prev_origin;
    logic frame_start;

    // Frame-start detection, state/counter update and pixel colour selection
    always_comb begin
        at_origin   = (ram_addr_x == 8'd0) && (ram_addr_y == 8'd0);
        prev_origin = (prev_x_q == 8'd0) && (prev_y_q == 8'd0);
        // Holding (0,0) over several cycles only counts on the first one
        frame_start = at_origin && !prev_origin;

        prev_x_d = ram_addr_x;
        prev_y_d = ram_addr_y;
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        first_d  = first_q;

        // A go coinciding with a frame start is kept for the next one
        go_pending_d = go || (go_pending_q && !frame_start);

        if (frame_start) begin
            first_d = 1'b0;
            if (go_pending_q) begin
                state_d = ST_SMILE;
                fcnt_d  = 8'd0;
            end else if (first_q) begin
                // First frame after reset is frame 0 of IDLE
                state_d = ST_IDLE;
                fcnt_d  = 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fcnt_q == IDLE_LAST) begin
                            state_d = ST_BLINK;
                            fcnt_d  = 8'd0;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    ST_BLINK: begin
                        if (fcnt_q == BLINK_LAST) begin
                            state_d = ST_IDLE;
                            fcnt_d  = 8'd0;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    ST_SMILE: begin
                        if (fcnt_q == SMILE_LAST) begin
                            state_d = ST_IDLE;
                            fcnt_d  = 8'd0;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        fcnt_d  = 8'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end

        // The pixel uses the post-update state so the (0,0) pixel matches its frame
        ram_data_d   = pixel_colour(ram_addr_x, ram_addr_y, state_d);
        frame_tick_d = frame_start;
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_x_q     <= 8'hFF;
            prev_y_q     <= 8'hFF;
            state_q      <= ST_IDLE;
            fcnt_q       <= 8'd0;
            go_pending_q <= 1'b0;
            first_q      <= 1'b1;
            ram_data_q   <= COL_BG;
            frame_tick_q <= 1'b0;
        end else begin
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            go_pending_q <= go_pending_d;
            first_q      <= first_d;
            ram_data_q   <= ram_data_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign ram_data   = ram_data_q;
    assign anim_state = state_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_face_anim_source.sv
// -----------------------------------------------------------------------------
// Testbench for face_anim_source. Frames are short: a (0,0) address followed
// by a handful of random addresses. A behavioural model counts frames left in
// each state and paints pixels from plain geometric rules; a negedge process
// compares every output each cycle, and a few literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_face_anim_source;

    localparam int W  = 132;
    localparam int H  = 162;
    localparam int IF = 90;
    localparam int BF = 4;
    localparam int SF = 60;

    localparam logic [15:0] BG    = 16'h2935;
    localparam logic [15:0] EYE   = 16'hFFFF;
    localparam logic [15:0] MOUTH = 16'hF800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go  = 1'b0;
    logic [7:0]  ax  = 8'd0;
    logic [7:0]  ay  = 8'd0;
    logic [15:0] ram_data;
    logic [1:0]  anim_state;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    face_anim_source #(
        .LCD_W(W), .LCD_H(H), .IDLE_FRAMES(IF), .BLINK_FRAMES(BF), .SMILE_FRAMES(SF)
    ) dut (
        .clk(clk), .rst(rst), .go(go),
        .ram_addr_x(ax), .ram_addr_y(ay),
        .ram_data(ram_data), .anim_state(anim_state), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state;
    int          m_left;
    bit          m_pending;
    bit          m_first;
    bit          m_valid = 1'b0;
    int          m_px;
    int          m_py;
    logic [15:0] e_data;
    int          e_state;
    bit          e_tick;

    function automatic logic [15:0] ref_colour(input int x, input int y, input int st);
        bit eye_col;
        bit eye_row;
        if (x >= W || y >= H) return BG;
        eye_col = (x >= 36 && x <= 51) || (x >= 80 && x <= 95);
        eye_row = (st == 1) ? (y == 57 || y == 58) : (y >= 50 && y <= 65);
        if (eye_col && eye_row) return EYE;
        if (st == 2) begin
            if (y >= 110 && y <= 113 && x >= 52 && x <= 79) return MOUTH;
            if (y >= 106 && y <= 109 && ((x >= 46 && x <= 51) || (x >= 80 && x <= 85)))
                return MOUTH;
        end else begin
            if (y >= 112 && y <= 113 && x >= 52 && x <= 79) return MOUTH;
        end
        return BG;
    endfunction

    task automatic model_step();
        bit fs;
        if (rst) begin
            m_valid = 1'b1; m_state = 0; m_left = 0; m_pending = 1'b0; m_first = 1'b1;
            m_px = 255; m_py = 255; e_data = BG; e_state = 0; e_tick = 1'b0;
        end else if (m_valid) begin
            fs = (ax == 8'd0 && ay == 8'd0) && !(m_px == 0 && m_py == 0);
            if (fs) begin
                if (m_pending) begin
                    m_state = 2; m_left = SF;
                end else if (m_first) begin
                    m_state = 0; m_left = IF;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_state == 0) begin
                            m_state = 1; m_left = BF;
                        end else begin
                            m_state = 0; m_left = IF;
                        end
                    end
                end
                m_first = 1'b0;
            end
            m_pending = go || (m_pending && !fs);
            e_tick  = fs;
            e_state = m_state;
            e_data  = ref_colour(int'(ax), int'(ay), m_state);
            m_px = int'(ax);
            m_py = int'(ay);
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("ram_data", int'(ram_data), int'(e_data));
            check("anim_state", int'(anim_state), e_state);
            check("frame_tick", int'(frame_tick), int'(e_tick));
            if (frame_tick) ticks++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] x, input logic [7:0] y,
                         input logic g, input logic r);
        @(negedge clk);
        ax = x; ay = y; go = g; rst = r;
    endtask

    task automatic rand_addr(output logic [7:0] x, output logic [7:0] y);
        if ($urandom_range(0, 1) == 1) begin
            x = 8'($urandom_range(30, 100));
            y = 8'($urandom_range(45, 120));
        end else begin
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
        end
        if (x == 8'd0 && y == 8'd0) x = 8'd1;
    endtask

    task automatic start_frame(input logic g, input int hold, input int exp_st, input string nm);
        drive(8'd0, 8'd0, g, 1'b0);
        @(posedge clk);
        #1;
        if (exp_st >= 0) check(nm, int'(anim_state), exp_st);
        for (int i = 1; i < hold; i++) drive(8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic body(input int n, input bit go_mid);
        logic [7:0] x;
        logic [7:0] y;
        for (int i = 0; i < n; i++) begin
            rand_addr(x, y);
            drive(x, y, go_mid && (i == n / 2), 1'b0);
        end
    endtask

    task automatic probe(input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp, input string nm);
        drive(x, y, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check(nm, int'(ram_data), int'(exp));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        logic [7:0] x;
        logic [7:0] y;

        // Reset state
        drive(8'd40, 8'd55, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("reset_data", int'(ram_data), int'(BG));
        check("reset_state", int'(anim_state), 0);
        check("reset_tick", int'(frame_tick), 0);

        // Frame 1: fixed pixels in IDLE
        start_frame(1'b0, 1, 0, "f1_state");
        check("origin_bg", int'(ram_data), int'(BG));
        probe(8'd40, 8'd55, EYE, "open_eye");
        probe(8'd60, 8'd112, MOUTH, "neutral_mouth");
        probe(8'd60, 8'd110, BG, "above_neutral_mouth");
        probe(8'd140, 8'd170, BG, "offscreen");

        // Frames 2..90 stay IDLE, 91..94 BLINK, 95 back to IDLE
        for (int f = 2; f <= 90; f++) begin
            start_frame(1'b0, 1, (f == 90) ? 0 : -1, "idle_f90");
            body(5, 1'b0);
        end
        start_frame(1'b0, 1, 1, "blink_at_f91");
        probe(8'd40, 8'd55, BG, "closed_eye_open_row");
        probe(8'd40, 8'd57, EYE, "closed_eye_row");
        for (int f = 92; f <= 94; f++) begin
            start_frame(1'b0, 1, 1, "blink_held");
            body(4, 1'b0);
        end
        start_frame(1'b0, 1, 0, "idle_at_f95");

        // go mid-frame in IDLE: no change until next frame start
        body(2, 1'b0);
        rand_addr(x, y);
        drive(x, y, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("state_after_go", int'(anim_state), 0);
        body(3, 1'b0);
        start_frame(1'b0, 1, 2, "smile_start");
        probe(8'd48, 8'd107, MOUTH, "smile_corner");
        probe(8'd60, 8'd110, MOUTH, "smile_lip");
        body(2, 1'b0);
        for (int f = 1; f <= 60; f++) begin
            start_frame(1'b0, 1, (f == 59) ? 2 : ((f == 60) ? 0 : -1), "smile_60");
            body(5, f == 60);
        end

        // Smile started; go in smile frame 50 re-arms for 60 more frames
        for (int f = 0; f <= 110; f++) begin
            start_frame(1'b0, 1, (f == 0 || f == 109) ? 2 : ((f == 110) ? 0 : -1), "smile_110");
            body(5, f == 49);
        end

        // go in the same cycle as (0,0)
        start_frame(1'b1, 1, 0, "go_at_origin_unchanged");
        body(4, 1'b0);
        start_frame(1'b0, 1, 2, "smile_after_origin_go");
        body(4, 1'b0);

        // Held (0,0) produces one tick, then reset mid-frame in SMILE
        t0 = ticks;
        start_frame(1'b0, 5, 2, "hold_state");
        body(3, 1'b0);
        check("tick_once", ticks - t0, 1);
        drive(8'd40, 8'd55, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("midreset_data", int'(ram_data), int'(BG));
        check("midreset_state", int'(anim_state), 0);
        body(3, 1'b0);
        for (int f = 1; f <= 91; f++) begin
            start_frame(1'b0, 1, (f == 90) ? 0 : ((f == 91) ? 1 : -1), "reblink_f91");
            body(4, 1'b0);
        end

        // Randomized frames with random go pulses and held origins
        for (int f = 0; f < 80; f++) begin
            start_frame(logic'($urandom_range(0, 15) == 0), $urandom_range(1, 3), -1, "");
            body($urandom_range(2, 10), $urandom_range(0, 5) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
